// File: rtl/dmem_responder.sv
// Word-addressed data memory behind a valid/ready request port; answers after LATENCY cycles.
// Latency: LATENCY edges from accept to resp_valid; req_ready low while waiting, no queuing.
// Backpressure: one outstanding request; new requests are taken only in IDLE or RESP.
module dmem_responder #(
    parameter int ADDR_BITS = 12,
    parameter int LATENCY   = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q_dmem,
    output logic        resp_valid,
    output logic        resp_err
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic        wren_q;
    logic        ready_q;
    logic        valid_q;
    logic        err_q;
    logic [31:0] q_q;

    logic [31:0] mem [0:(1 << ADDR_BITS) - 1];

    logic                 accept;
    logic                 commit_en;
    logic [31:0]          c_addr;
    logic [31:0]          c_data;
    logic                 c_wren;
    logic                 in_range;
    logic [ADDR_BITS-1:0] idx;

    assign accept = req_valid & ready_q;

    // With LATENCY==1 the commit happens on the accept edge itself, straight from the inputs.
    always_comb begin
        commit_en = 1'b0;
        c_addr    = addr_q;
        c_data    = data_q;
        c_wren    = wren_q;
        if (accept && LATENCY == 1) begin
            commit_en = 1'b1;
            c_addr    = address_dmem;
            c_data    = data;
            c_wren    = wren;
        end else if (state_q == WAIT && cnt_q == 4'd1) begin
            commit_en = 1'b1;
        end
        if (reset) begin
            commit_en = 1'b0;
        end
    end

    assign in_range = (c_addr >> ADDR_BITS) == 32'd0;
    assign idx      = c_addr[ADDR_BITS-1:0];

    // Storage is deliberately not reset; a reset edge never commits a write.
    always_ff @(posedge clock) begin
        if (commit_en && c_wren && in_range) begin
            mem[idx] <= c_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            data_q  <= 32'd0;
            wren_q  <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            q_q     <= 32'd0;
        end else begin
            valid_q <= commit_en;
            err_q   <= commit_en & ~in_range;
            case (state_q)
                IDLE, RESP: begin
                    if (accept) begin
                        addr_q <= address_dmem;
                        data_q <= data;
                        wren_q <= wren;
                        cnt_q  <= 4'(LATENCY - 1);
                        if (LATENCY == 1) begin
                            state_q <= RESP;
                            ready_q <= 1'b1;
                        end else begin
                            state_q <= WAIT;
                            ready_q <= 1'b0;
                        end
                    end else begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd1) begin
                        state_q <= RESP;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
            if (commit_en) begin
                if (!in_range) begin
                    q_q <= 32'd0;
                end else if (!c_wren) begin
                    q_q <= mem[idx];
                end
            end
        end
    end

    assign req_ready  = ready_q;
    assign resp_valid = valid_q;
    assign resp_err   = err_q;
    assign q_dmem     = q_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory target for the pipelined core's dmem interface.
- Accepts word-addressed read/write requests from the processor through a valid/ready handshake and returns read data after a fixed, parameterised latency.
- Holds the backing storage array and flags out-of-range accesses.
- Sits between the processor's address_dmem/data/wren outputs and its q_dmem input; the processor stalls on req_ready/resp_valid.

Parameters:
- ADDR_BITS, 12, word-address width of storage; array holds 2^ADDR_BITS 32-bit words.
- LATENCY, 2, cycles from request acceptance edge to resp_valid cycle; legal range 1..15.

Ports:
- clock  in  1  master clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  processor presents a request this cycle.
- req_ready  out  1  responder can accept a request this cycle.
- address_dmem  in  32  word address of the request.
- data  in  32  write data; ignored for reads.
- wren  in  1  1 = write request, 0 = read request.
- q_dmem  out  32  read data; valid while resp_valid is high, held afterwards.
- resp_valid  out  1  one-cycle pulse marking response/acknowledge.
- resp_err  out  1  qualifies resp_valid; 1 = out-of-range access.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high, sampled on the rising edge of clock.
- Reset values: FSM=IDLE, req_ready=1, resp_valid=0, resp_err=0, q_dmem=0, latency counter=0, request holding registers=0.
- Reset does not clear the storage array.
- FSM states: IDLE, WAIT, RESP.
- Accept: a request is accepted on a rising edge where req_valid&req_ready=1. At that edge, address_dmem, data and wren are captured into holding registers; the inputs may change afterwards.
- Counter: on accept, counter loads LATENCY-1. If LATENCY==1, go directly to RESP; otherwise go to WAIT.
- WAIT: req_ready=0. Counter decrements each edge. On the edge where the counter equals 1, go to RESP.
- Timing: a request accepted at edge k has resp_valid high during the cycle following edge k+LATENCY-1, so exactly LATENCY cycles after acceptance.
- Commit: on the edge entering RESP, the access is committed.
  - Read: q_dmem <= mem[addr[ADDR_BITS-1:0]].
  - Write: mem[addr] <= data; q_dmem keeps its previous value.
- Range check: an address is out of range if any bit address[31:ADDR_BITS] is nonzero. Then no write occurs, q_dmem <= 0, and resp_err=1 in the RESP cycle. Otherwise resp_err=0.
- RESP: resp_valid=1 for exactly one cycle. req_ready=1.
  - If req_valid: accept the new request (back-to-back) and go to WAIT or RESP per LATENCY.
  - Otherwise go to IDLE.
- Throughput: one request per LATENCY cycles maximum.
- Read-after-write: a read accepted in the RESP cycle of a write to the same address returns the new data.
- Write-after-read: a read's data is captured at its own commit and is unaffected by later writes.
- q_dmem holds its last read value until the next read or out-of-range commit. resp_err is 0 outside RESP.
- Reset mid-operation (WAIT or RESP): the pending request is dropped, a pending write is NOT committed, and all outputs return to reset values on that edge. The array retains prior contents.
- Request inputs are ignored while req_ready=0; no queuing.
- Address width: only address[ADDR_BITS-1:0] indexes the array; wrap-around is not permitted (upper bits are error-checked, not truncated).

Test Plan:
- LATENCY=2. Write 32'hDEADBEEF to addr 5 at edge 0, then read addr 5 in the RESP cycle -> write resp_valid in cycle 2 with resp_err=0; read resp_valid in cycle 4 with q_dmem=32'hDEADBEEF.
- LATENCY=1. Back-to-back reads of addrs 0..3, preloaded with 10..13, with req_valid held high -> req_ready stays 1; resp_valid high every cycle; q_dmem=10,11,12,13 in consecutive cycles.
- LATENCY=3. Issue a read, then toggle req_valid, address_dmem and data during WAIT -> req_ready=0 for 2 cycles; the inputs are ignored; exactly one response, for the original address.
- ADDR_BITS=12. Write 32'h1234 to addr 32'h0000_1005 -> resp_err=1 with resp_valid. A subsequent read of addr 5 returns the prior value (not 32'h1234). A read of 32'h0000_1005 returns q_dmem=0 and resp_err=1.
- LATENCY=3. Write 32'hAAAA to addr 7 (prior value 32'h5555), then assert reset in the first WAIT cycle -> the next edge gives req_ready=1, resp_valid=0, q_dmem=0; a later read of addr 7 returns 32'h5555.
- Idle after reset with req_valid=0 for 10 cycles -> resp_valid=0, resp_err=0, q_dmem=0, req_ready=1 throughout.
